// File: rtl/alu4_result_stage.sv
// ============================================================================
// Module   : alu4_result_stage
// Purpose  : Registered 4-bit ALU output stage with flags and a 2-entry
//            valid/ready result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu4_result_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int ENTRY_W = WIDTH + 4;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOT   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;

    logic [WIDTH-1:0]   w_y;
    logic               w_carry;
    logic               w_ovf;
    logic               w_err;
    logic               w_zero;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_push;
    logic               w_pop;

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic [CNT_W-1:0]   r_done_cnt;

    always_comb begin
        w_y     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        case (op)
            OP_AND:   w_y = a & b;
            OP_OR:    w_y = a | b;
            OP_XOR:   w_y = a ^ b;
            OP_NOT:   w_y = ~a;
            OP_ADD: begin
                w_y     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Borrow out of the extended subtraction means a < b.
                w_y     = w_diff[WIDTH-1:0];
                w_carry = ~w_diff[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_PASSB: w_y = b;
            default:  w_err = 1'b1;
        endcase
    end

    assign w_zero  = (w_y == '0);
    assign w_entry = {w_y, w_carry, w_zero, w_ovf, w_err};

    // Ready depends only on occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_done_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr   <= ~r_rd_ptr;
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign {y, carry, zero, ovf, err} = r_mem[r_rd_ptr];
    assign done_cnt = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu4_result_stage.sv
// ============================================================================
// Module   : tb_alu4_result_stage
// Purpose  : Scoreboard bench for alu4_result_stage using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu4_result_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] y;
    logic       carry, zero, ovf, err;
    logic [7:0] done_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q [$];

    alu4_result_stage #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .zero(zero), .ovf(ovf), .err(err),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected entry layout: {y[3:0], carry, zero, ovf, err}
    task automatic issue(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] bb,
                         input logic [7:0] e);
        bit ok = 0;
        in_valid = 1'b1; op = o; a = aa; b = bb;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("issue_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("scoreboard_unexpected", 32'({y, carry, zero, ovf, err}), 32'hFFFF_FFFF);
            end else begin
                check("scoreboard", 32'({y, carry, zero, ovf, err}), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] and_tab [16] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2,
                                 4'h8, 4'h8, 4'hA, 4'hA, 4'h8, 4'h8, 4'hA, 4'hA};

    initial begin
        #12;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_head", 32'({y, carry, zero, ovf, err}), 0);
        check("reset_done_cnt", 32'(done_cnt), 0);
        do_reset();

        // AND, then sweep a with b = 1010; back-to-back issues also exercise push+pop at count 1
        out_ready = 1'b1;
        issue(3'b000, 4'b1010, 4'b1100, {4'b1000, 4'b0000});
        check("latency_out_valid", 32'(out_valid), 1);
        check("latency_y", 32'(y), 32'h8);
        for (int i = 0; i < 16; i++)
            issue(3'b000, 4'(i), 4'b1010, {and_tab[i], 1'b0, (and_tab[i] == 4'h0), 2'b00});

        // Arithmetic flags
        issue(3'b100, 4'b1111, 4'b0001, {4'b0000, 4'b1100});
        issue(3'b100, 4'b0111, 4'b0001, {4'b1000, 4'b0010});
        issue(3'b101, 4'b0011, 4'b0101, {4'b1110, 4'b0000});
        issue(3'b101, 4'b1000, 4'b0001, {4'b0111, 4'b1010});
        drain();
        check("done_cnt_21", 32'(done_cnt), 21);

        // Backpressure with ordering
        do_reset();
        out_ready = 1'b0;
        issue(3'b010, 4'b1111, 4'b0101, {4'b1010, 4'b0000});
        issue(3'b001, 4'b0001, 4'b0010, {4'b0011, 4'b0000});
        fork
            issue(3'b011, 4'b0000, 4'b0000, {4'b1111, 4'b0000});
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 0);
                    check("bp_head_y", 32'({out_valid, y}), 32'h1A);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_done_cnt", 32'(done_cnt), 3);

        // Illegal opcode, then PASSB/ADD/SUB back-to-back for ordering
        issue(3'b111, 4'b1010, 4'b0101, {4'b0000, 4'b0101});
        issue(3'b110, 4'b0110, 4'b1001, {4'b1001, 4'b0000});
        issue(3'b100, 4'b0101, 4'b0011, {4'b1000, 4'b0010});
        issue(3'b101, 4'b0101, 4'b0101, {4'b0000, 4'b1100});
        drain();
        check("done_cnt_7", 32'(done_cnt), 7);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        issue(3'b110, 4'b0000, 4'b0011, {4'b0011, 4'b0000});
        issue(3'b110, 4'b0000, 4'b0100, {4'b0100, 4'b0000});
        check("full_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_in_ready", 32'(in_ready), 1);
        check("async_done_cnt", 32'(done_cnt), 0);
        check("async_head", 32'({y, carry, zero, ovf, err}), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 256 consumed results wrap done_cnt back to zero
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            issue(3'b110, 4'b0000, 4'(i), {4'(i), 1'b0, (4'(i) == 4'h0), 2'b00});
        drain();
        check("done_cnt_wrap", 32'(done_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
